dpwm: RTL and testbench
=======================

// Module: dpwm
// PURPOSE
//  Digital pulse-width modulator: converts a WIDTH-bit duty reference into a fixed-frequency
//  PWM waveform with period 2**WIDTH clock cycles and high time Ref cycles. Sits between the
//  digital controller (drives Ref) and the power-stage gate driver (consumes Signal_o).
//  The reference is sampled once per period so that duty changes never produce runt pulses.
// PARAMETERS
//  WIDTH   4   bit width of Ref and of the period counter; period = 2**WIDTH cycles (16)
// PORTS
//  f_in      in   1      clock, rising-edge active (sole clock of the block)
//  rst_n     in   1      reset, synchronous, active-low
//  Ref       in   WIDTH  duty reference, unsigned; high cycles per period (0..2**WIDTH-1)
//  Signal_o  out  1      PWM output, registered
// BEHAVIOUR
//  - Interface: one clock (f_in); reset rst_n is synchronous and active-low.
//  - Reset (rst_n=0 at a rising f_in): cnt<=0, ref_q<=0, Signal_o<=0. Holds while asserted.
//  - cnt: WIDTH-bit free-running up-counter, +1 every cycle, wraps 2**WIDTH-1 -> 0.
//  - ref_q: shadow register; loads Ref on the cycle cnt==2**WIDTH-1, so the new value
//    governs the period starting at cnt==0. Ref changes mid-period are ignored until then.
//  - First period after reset release uses ref_q=0 (output low); Ref is picked up at the
//    first wrap (cnt 15->0).
//  - Compare: hi = (cnt < ref_q), unsigned, combinational.
//  - Signal_o <= hi every cycle: 1-cycle latency from cnt to output; pulse is high for
//    exactly ref_q consecutive cycles starting one cycle after cnt==0, then low for the rest.
//  - Boundaries: ref_q=0 -> Signal_o constantly 0 (0%); ref_q=2**WIDTH-1 -> high 15 of 16
//    cycles (max duty, never 100%); no glitches, output changes only on rising f_in.
//  - Reset mid-period: output forced low next edge, counter restarts at 0, ref_q cleared.
//  - Ref with X/Z is not supported; caller guarantees a clean value at the sampling edge.
// STRUCTURE
//  - Shared package dpwm_pkg: localparam DPWM_WIDTH=4, localparam DPWM_PERIOD=2**DPWM_WIDTH.
//  - One natural sub-module: dpwm_counter (WIDTH-bit wrap counter with rst_n, outputs cnt
//    and a one-cycle terminal-count strobe tc = (cnt==2**WIDTH-1) used to load ref_q).
//  - Top dpwm: instantiates dpwm_counter, holds ref_q, comparator and output register.
// TESTING
//  Clock f_in period 2000 ns; all checks sampled after rising edges.
//  1) rst_n=0 for 3 cycles, Ref=9 -> Signal_o=0, cnt=0 throughout reset.
//  2) Release reset, Ref=9 -> first period all low; thereafter every 16 cycles exactly
//     9 high then 7 low, high run beginning 1 cycle after cnt==0.
//  3) Change Ref 9->1 at cnt==5 -> current period keeps 9-high; next period 1 high, 15 low.
//  4) Ref=5 steady for 25 cycles -> duty 5/16, period 16 cycles, no pulse shorter than 5.
//  5) Ref=0 then Ref=15 -> output stays 0 for full periods; then 15 high / 1 low per period.
//  6) Assert rst_n=0 mid-high-pulse with Ref=9 -> Signal_o=0 on next edge; after release
//     one low period, then 9/16 duty resumes aligned to new cnt==0.

Source files
------------

// File: rtl/dpwm_pkg.sv
// Shared constants for the digital PWM block.
// Holds the default counter width and the derived period length.
package dpwm_pkg;

    localparam int DPWM_WIDTH  = 4;
    localparam int DPWM_PERIOD = 2 ** DPWM_WIDTH;

endpackage

// File: rtl/dpwm_counter.sv
// Free-running WIDTH-bit period counter with terminal-count strobe.
// Ports: clk_i clock, rst_ni sync active-low reset,
//        cnt_o current count, tc_o high while cnt_o is all ones.
module dpwm_counter
    import dpwm_pkg::*;
#(
    parameter int WIDTH = DPWM_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Natural binary overflow provides the wrap to zero.
    assign cnt_d = cnt_q + WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == {WIDTH{1'b1}});

endmodule

// File: rtl/dpwm.sv
// Digital PWM: period 2**WIDTH cycles, high time set by a shadowed duty reference.
// Ports: f_in clock, rst_n sync active-low reset,
//        Ref duty reference (high cycles per period), Signal_o registered PWM output.
module dpwm
    import dpwm_pkg::*;
#(
    parameter int WIDTH = DPWM_WIDTH
) (
    input  logic             f_in,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ref,
    output logic             Signal_o
);

    logic [WIDTH-1:0] cnt;
    logic             tc;

    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] ref_d;
    logic             sig_q;
    logic             sig_d;

    dpwm_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk_i  (f_in),
        .rst_ni (rst_n),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    // Shadow load on the last count so a new duty only takes effect
    // at a period boundary and can never truncate a running pulse.
    assign ref_d = tc ? Ref : ref_q;

    // Count 2**WIDTH-1 is never below any reference, so the output is
    // always low for at least one cycle per period.
    assign sig_d = (cnt < ref_q);

    always_ff @(posedge f_in) begin
        if (!rst_n) begin
            ref_q <= '0;
            sig_q <= 1'b0;
        end else begin
            ref_q <= ref_d;
            sig_q <= sig_d;
        end
    end

    assign Signal_o = sig_q;

endmodule

// File: tb/tb_dpwm.sv
// Self-checking bench for dpwm against a cycle-index reference model.
// Directed scenarios followed by randomized duty changes and resets.
`timescale 1ns/1ps
module tb_dpwm;
    import dpwm_pkg::*;

    logic       f_in;
    logic       rst_n;
    logic [3:0] Ref;
    logic       Signal_o;

    int n_cmp;
    int n_bad;

    // Reference model state: cycles since reset release and duty in force.
    int n_cyc;
    int duty;
    logic exp_sig;
    int   exp_cnt;

    dpwm #(.WIDTH(DPWM_WIDTH)) dut (
        .f_in     (f_in),
        .rst_n    (rst_n),
        .Ref      (Ref),
        .Signal_o (Signal_o)
    );

    initial f_in = 1'b0;
    always #1000 f_in = ~f_in;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One rising edge: advance the model using the inputs seen at the edge,
    // then compare output and counter shortly after.
    task automatic tick();
        @(posedge f_in);
        if (!rst_n) begin
            n_cyc   = 0;
            duty    = 0;
            exp_sig = 1'b0;
        end else begin
            exp_sig = ((n_cyc % DPWM_PERIOD) < duty);
            if ((n_cyc % DPWM_PERIOD) == DPWM_PERIOD - 1)
                duty = int'(Ref);
            n_cyc++;
        end
        exp_cnt = n_cyc % DPWM_PERIOD;
        #1;
        check_eq("signal", int'(Signal_o), int'(exp_sig));
        check_eq("cnt", int'(dut.cnt), exp_cnt);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic run_to_pos(input int pos);
        for (int i = 0; i < DPWM_PERIOD + 1; i++) begin
            if ((n_cyc % DPWM_PERIOD) == pos) return;
            tick();
        end
        check_eq("pos_timeout", n_cyc % DPWM_PERIOD, pos);
    endtask

    // Count the high cycles of one full period, starting just after cnt==0.
    task automatic duty_period(input string tag, input int exp_hi);
        int hi;
        hi = 0;
        run_to_pos(0);
        for (int i = 0; i < DPWM_PERIOD; i++) begin
            tick();
            if (Signal_o) hi++;
        end
        check_eq(tag, hi, exp_hi);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_cyc = 0;
        duty  = 0;
        rst_n = 1'b0;
        Ref   = 4'd9;

        // Reset held for three edges.
        run(3);

        // Release: first period low, then 9/16.
        @(negedge f_in);
        rst_n = 1'b1;
        duty_period("first_period", 0);
        duty_period("duty9_a", 9);
        duty_period("duty9_b", 9);

        // Mid-period change is deferred to the next boundary.
        run_to_pos(5);
        Ref = 4'd1;
        run(DPWM_PERIOD - 5);
        duty_period("duty1", 1);

        // Steady 5/16.
        Ref = 4'd5;
        run(25);
        duty_period("duty5", 5);

        // Extremes.
        Ref = 4'd0;
        run(DPWM_PERIOD);
        duty_period("duty0", 0);
        Ref = 4'd15;
        run(DPWM_PERIOD);
        duty_period("duty15", 15);

        // Reset in the middle of a high pulse.
        Ref = 4'd9;
        run(DPWM_PERIOD);
        run_to_pos(4);
        check_eq("mid_pulse_high", int'(Signal_o), 1);
        @(negedge f_in);
        rst_n = 1'b0;
        tick();
        @(negedge f_in);
        rst_n = 1'b1;
        duty_period("post_rst_low", 0);
        duty_period("post_rst_duty9", 9);

        // Randomized duty changes with occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge f_in);
            if ($urandom_range(0, 9) == 0) Ref = 4'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
